// File: rtl/pipe_pkg.sv
// Shared definitions for the pipeline stage register: state encoding,
// the RV32I NOP used as the bubble payload, and the perf counter width.
package pipe_pkg;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    FULL1 = 2'd1,
    FULL2 = 2'd2
  } state_e;

  localparam logic [31:0] RV32I_NOP = 32'h0000_0013;
  localparam int          PERF_W    = 32;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Valid/ready channel bundle around one pipeline stage register.
// master = surrounding pipeline (upstream + downstream), slave = the stage.
interface pipe_stage_reg_if #(
  parameter int PC_W   = 32,
  parameter int DATA_W = 32
);

  logic              flush;
  logic              in_valid;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc;
  logic [DATA_W-1:0] in_data;
  logic              out_valid;
  logic              out_ready;
  logic [PC_W-1:0]   out_pc;
  logic [DATA_W-1:0] out_data;
  logic [1:0]        occupancy;

  modport master (
    output flush, in_valid, in_pc, in_data, out_ready,
    input  in_ready, out_valid, out_pc, out_data, occupancy
  );

  modport slave (
    input  flush, in_valid, in_pc, in_data, out_ready,
    output in_ready, out_valid, out_pc, out_data, occupancy
  );

endinterface

// File: rtl/pipe_slot.sv
// One PC + payload holding register with load-enable and a synchronous
// clear that returns it to (PC 0, bubble payload). Clear wins over load.
module pipe_slot #(
  parameter int                PC_W   = 32,
  parameter int                DATA_W = 32,
  parameter logic [DATA_W-1:0] BUBBLE = '0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              load,
  input  logic [PC_W-1:0]   d_pc,
  input  logic [DATA_W-1:0] d_data,
  output logic [PC_W-1:0]   q_pc,
  output logic [DATA_W-1:0] q_data
);

  // NOTE: non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (clear) begin
      q_pc   <= '0;
      q_data <= BUBBLE;
    end else if (load) begin
      q_pc   <= d_pc;
      q_data <= d_data;
    end
  end

endmodule

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register with valid/ready handshake, flush-to-bubble and an
// optional skid slot (SKID=1). Define PIPE_STAGE_PERF_EN for stall/flush counters.
module pipe_stage_reg
  import pipe_pkg::*;
#(
  parameter int          PC_W       = 32,
  parameter int          DATA_W     = 32,
  parameter logic [31:0] BUBBLE_VAL = RV32I_NOP,
  parameter int          SKID       = 1
) (
  input  logic              clk,
  input  logic              reset,
`ifdef PIPE_STAGE_PERF_EN
  output logic [PERF_W-1:0] stall_cnt,
  output logic [PERF_W-1:0] flush_cnt,
`endif
  pipe_stage_reg_if.slave   bus
);

  localparam logic [DATA_W-1:0] BUBBLE = DATA_W'(BUBBLE_VAL);

  state_e            state;
  state_e            state_nx;
  logic              rdy_en;
  logic              accept;
  logic              pop;
  logic              head_load;
  logic              head_clear;
  logic              head_from_skid;
  logic              skid_load;
  logic              skid_clear;
  logic [PC_W-1:0]   head_pc;
  logic [PC_W-1:0]   skid_pc;
  logic [PC_W-1:0]   head_d_pc;
  logic [DATA_W-1:0] head_data;
  logic [DATA_W-1:0] skid_data;
  logic [DATA_W-1:0] head_d_data;

  assign bus.out_valid = (state != EMPTY);
  assign bus.out_pc    = head_pc;
  assign bus.out_data  = head_data;
  assign bus.occupancy = state;

  // rdy_en keeps in_ready low through reset and for the reset cycle itself.
  if (SKID != 0) begin : g_rdy_skid
    assign bus.in_ready = rdy_en & (state != FULL2);
  end else begin : g_rdy_single
    assign bus.in_ready = rdy_en & (!bus.out_valid | bus.out_ready);
  end

  assign accept = bus.in_valid & bus.in_ready;
  assign pop    = bus.out_valid & bus.out_ready;

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= EMPTY;
      rdy_en <= 1'b0;
    end else begin
      state  <= state_nx;
      rdy_en <= 1'b1;
    end
  end

  // NOTE: every output gets a default first so no path infers a latch.
  always_comb begin
    state_nx       = state;
    head_load      = 1'b0;
    head_clear     = 1'b0;
    head_from_skid = 1'b0;
    skid_load      = 1'b0;
    skid_clear     = 1'b0;
    if (reset || bus.flush) begin
      state_nx   = EMPTY;
      head_clear = 1'b1;
      skid_clear = 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (accept) begin
            state_nx  = FULL1;
            head_load = 1'b1;
          end
        end
        FULL1: begin
          if (accept && pop) begin
            head_load = 1'b1;
          end else if (accept) begin
            // Only reachable with the skid slot: single entry needs out_ready to accept.
            state_nx  = FULL2;
            skid_load = 1'b1;
          end else if (pop) begin
            state_nx   = EMPTY;
            head_clear = 1'b1;
          end
        end
        FULL2: begin
          if (pop) begin
            state_nx       = FULL1;
            head_load      = 1'b1;
            head_from_skid = 1'b1;
            skid_clear     = 1'b1;
          end
        end
        default: begin
          state_nx   = EMPTY;
          head_clear = 1'b1;
          skid_clear = 1'b1;
        end
      endcase
    end
  end

  assign head_d_pc   = head_from_skid ? skid_pc   : bus.in_pc;
  assign head_d_data = head_from_skid ? skid_data : bus.in_data;

  pipe_slot #(
    .PC_W   (PC_W),
    .DATA_W (DATA_W),
    .BUBBLE (BUBBLE)
  ) u_head (
    .clk    (clk),
    .clear  (head_clear),
    .load   (head_load),
    .d_pc   (head_d_pc),
    .d_data (head_d_data),
    .q_pc   (head_pc),
    .q_data (head_data)
  );

  if (SKID != 0) begin : g_skid
    pipe_slot #(
      .PC_W   (PC_W),
      .DATA_W (DATA_W),
      .BUBBLE (BUBBLE)
    ) u_skid (
      .clk    (clk),
      .clear  (skid_clear),
      .load   (skid_load),
      .d_pc   (bus.in_pc),
      .d_data (bus.in_data),
      .q_pc   (skid_pc),
      .q_data (skid_data)
    );
  end else begin : g_no_skid
    logic skid_unused;
    assign skid_unused = skid_load | skid_clear;
    assign skid_pc     = '0;
    assign skid_data   = BUBBLE;
  end

`ifdef PIPE_STAGE_PERF_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (bus.out_valid && !bus.out_ready && (stall_cnt != '1))
        stall_cnt <= stall_cnt + PERF_W'(1);
      if (bus.flush && (state != EMPTY) && (flush_cnt != '1))
        flush_cnt <= flush_cnt + PERF_W'(1);
    end
  end
`endif

endmodule
